// File: rtl/piezo_alarm_unit.sv
// piezo_alarm_unit: plays a repeating 8-note melody on PIEZO after an ALARM_DOING rise, with stop, snooze and auto-timeout
module piezo_alarm_unit #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned NOTE_CYC      = 12_500_000,
    parameter int unsigned GAP_CYC       = 2_500_000,
    parameter int unsigned TIMEOUT_NOTES = 240,
    parameter int unsigned SNOOZE_CYC    = 50_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ALARM_DOING,
    input  logic STOP,
    input  logic SNOOZE,
    output logic PIEZO,
    output logic RINGING,
    output logic SNOOZING
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP, SNOOZE_WAIT} state_t;
    // half-periods for C5 D5 E5 F5 G5 A5 B5 C6
    localparam logic [31:0] HP [8] = '{
        CLK_HZ / (2 * 523), CLK_HZ / (2 * 587), CLK_HZ / (2 * 659), CLK_HZ / (2 * 698),
        CLK_HZ / (2 * 784), CLK_HZ / (2 * 880), CLK_HZ / (2 * 988), CLK_HZ / (2 * 1047)
    };
    state_t state, state_n;
    logic [31:0] cnt, cnt_n, tone, tone_n, played, played_n;
    logic [2:0] idx, idx_n;
    logic alarm_q, piezo_n, trig, wrap, active;
    always_comb begin
        trig = ALARM_DOING && !alarm_q;
        wrap = tone == HP[idx] - 32'd1;
        active = state == PLAY || state == GAP;
        state_n = state;
        cnt_n = cnt + 32'd1;
        tone_n = '0;
        idx_n = idx;
        played_n = played;
        piezo_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (trig) begin
                    state_n = PLAY;
                    idx_n = '0;
                    played_n = '0;
                end
            end
            PLAY: begin
                if (cnt == NOTE_CYC - 1) begin
                    state_n = GAP;
                    cnt_n = '0;
                end else begin
                    tone_n = wrap ? '0 : tone + 32'd1;
                    piezo_n = PIEZO ^ wrap;
                end
            end
            GAP: begin
                if (cnt == GAP_CYC - 1) begin
                    state_n = played + 32'd1 == TIMEOUT_NOTES ? IDLE : PLAY;
                    cnt_n = '0;
                    idx_n = idx + 3'd1;
                    played_n = played + 32'd1;
                end
            end
            SNOOZE_WAIT: begin
                if (cnt == SNOOZE_CYC - 1) begin
                    state_n = PLAY;
                    cnt_n = '0;
                    idx_n = '0;
                    played_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // key pulses override any expiry transition; STOP beats SNOOZE
        if (STOP && state != IDLE) begin
            state_n = IDLE;
            cnt_n = '0;
            tone_n = '0;
            idx_n = '0;
            played_n = '0;
            piezo_n = 1'b0;
        end else if (SNOOZE && active) begin
            state_n = SNOOZE_WAIT;
            cnt_n = '0;
            tone_n = '0;
            piezo_n = 1'b0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt <= '0;
            tone <= '0;
            idx <= '0;
            played <= '0;
            alarm_q <= 1'b0;
            PIEZO <= 1'b0;
            RINGING <= 1'b0;
            SNOOZING <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            tone <= tone_n;
            idx <= idx_n;
            played <= played_n;
            alarm_q <= ALARM_DOING;
            PIEZO <= piezo_n;
            RINGING <= state_n == PLAY || state_n == GAP;
            SNOOZING <= state_n == SNOOZE_WAIT;
        end
    end
endmodule

// File: tb/tb_piezo_alarm_unit.sv
// tb_piezo_alarm_unit: table-driven and scoreboard checks of the alarm melody sequencer
module tb_piezo_alarm_unit;
    localparam int CLK_HZ = 1_000_000;
    localparam int NOTE_CYC = 2000;
    localparam int GAP_CYC = 500;
    localparam int TIMEOUT_NOTES = 10;
    localparam int SNOOZE_CYC = 3000;
    localparam int PERIOD = NOTE_CYC + GAP_CYC;
    localparam int FREQ [8] = '{523, 587, 659, 698, 784, 880, 988, 1047};

    typedef struct {
        string name;
        int pre;
        logic a, st, sn, ep, er, es;
    } vec_t;

    logic CLK = 0, RESET = 1, ALARM_DOING = 0, STOP = 0, SNOOZE = 0;
    logic PIEZO, RINGING, SNOOZING;
    int cyc = 0;
    int checks = 0, errors = 0;
    int exp_q[$], obs_q[$];
    logic last_p = 0;
    vec_t vt[$];

    piezo_alarm_unit #(
        .CLK_HZ(CLK_HZ), .NOTE_CYC(NOTE_CYC), .GAP_CYC(GAP_CYC),
        .TIMEOUT_NOTES(TIMEOUT_NOTES), .SNOOZE_CYC(SNOOZE_CYC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ALARM_DOING(ALARM_DOING), .STOP(STOP), .SNOOZE(SNOOZE),
        .PIEZO(PIEZO), .RINGING(RINGING), .SNOOZING(SNOOZING)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    // record the edge number of every PIEZO transition
    always @(negedge CLK) begin
        if (PIEZO !== last_p) obs_q.push_back(cyc);
        last_p <= PIEZO;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hp_of(input int i);
        return CLK_HZ / (2 * FREQ[i]);
    endfunction

    task automatic push_note(input int s, input int hp);
        int n = 0;
        for (int m = 1; m * hp < NOTE_CYC; m++) begin
            exp_q.push_back(s + m * hp);
            n++;
        end
        if (n % 2 == 1) exp_q.push_back(s + NOTE_CYC);
    endtask

    function automatic vec_t mk(input string name, input int pre,
                                input logic a, st, sn, ep, er, es);
        vec_t v;
        v.name = name; v.pre = pre; v.a = a; v.st = st; v.sn = sn;
        v.ep = ep; v.er = er; v.es = es;
        return v;
    endfunction

    task automatic chk_out(input string name, input logic ep, er, es);
        chk1({name, "_piezo"}, PIEZO, ep);
        chk1({name, "_ringing"}, RINGING, er);
        chk1({name, "_snoozing"}, SNOOZING, es);
    endtask

    initial begin
        int e, n;
        vt.push_back(mk("drop",            0,     0, 0, 0, 0, 0, 0));
        vt.push_back(mk("retrig",          0,     1, 0, 0, 0, 1, 0));
        vt.push_back(mk("snooze_note3",    7599,  1, 0, 1, 0, 0, 1));
        vt.push_back(mk("snooze_again",    999,   1, 0, 1, 0, 0, 1));
        vt.push_back(mk("snooze_last",     1998,  1, 0, 0, 0, 0, 1));
        vt.push_back(mk("wake",            0,     1, 0, 0, 0, 1, 0));
        vt.push_back(mk("wake_note0_lo",   954,   1, 0, 0, 0, 1, 0));
        vt.push_back(mk("wake_note0_hi",   0,     1, 0, 0, 1, 1, 0));
        vt.push_back(mk("played_reset",    19043, 1, 0, 0, 0, 1, 0));
        vt.push_back(mk("stop_gap",        2099,  1, 1, 0, 0, 0, 0));
        vt.push_back(mk("drop2",           0,     0, 0, 0, 0, 0, 0));
        vt.push_back(mk("trig2",           0,     1, 0, 0, 0, 1, 0));
        vt.push_back(mk("snooze2",         99,    1, 0, 1, 0, 0, 1));
        vt.push_back(mk("stop_snooze",     499,   1, 1, 0, 0, 0, 0));
        vt.push_back(mk("drop3",           0,     0, 0, 0, 0, 0, 0));
        vt.push_back(mk("trig3",           0,     1, 0, 0, 0, 1, 0));
        vt.push_back(mk("stop_and_snooze", 50,    1, 1, 1, 0, 0, 0));
        vt.push_back(mk("stays_idle",      10,    1, 0, 0, 0, 0, 0));
        vt.push_back(mk("drop4",           0,     0, 0, 0, 0, 0, 0));
        vt.push_back(mk("trig4",           0,     1, 0, 0, 0, 1, 0));
        vt.push_back(mk("snooze_note_end", 1999,  1, 0, 1, 0, 0, 1));
        vt.push_back(mk("stop_end",        0,     1, 1, 0, 0, 0, 0));

        step(3);
        chk_out("reset", 0, 0, 0);
        RESET = 0;
        step(2);
        chk_out("idle", 0, 0, 0);

        // full melody to auto-off, transitions scored against the note table
        obs_q.delete();
        exp_q.delete();
        ALARM_DOING = 1;
        step(1);
        e = cyc;
        chk1("trig_ringing", RINGING, 1);
        for (int k = 0; k < TIMEOUT_NOTES; k++) push_note(e + k * PERIOD, hp_of(k % 8));
        step(NOTE_CYC + 10);
        chk_out("gap", 0, 1, 0);
        step(TIMEOUT_NOTES * PERIOD - 1 - (NOTE_CYC + 10));
        chk1("last_gap_ringing", RINGING, 1);
        step(1);
        chk_out("timeout", 0, 0, 0);
        step(100);
        chk_out("no_retrig", 0, 0, 0);
        chkn("toggle_count", obs_q.size(), exp_q.size());
        n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chkn($sformatf("toggle%0d", i), obs_q[i] - e, exp_q[i] - e);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].pre);
            ALARM_DOING = vt[i].a;
            STOP = vt[i].st;
            SNOOZE = vt[i].sn;
            step(1);
            STOP = 0;
            SNOOZE = 0;
            chk_out(vt[i].name, vt[i].ep, vt[i].er, vt[i].es);
        end

        // reset mid-note with ALARM_DOING held high must re-trigger afterwards
        ALARM_DOING = 0;
        step(1);
        ALARM_DOING = 1;
        step(1);
        chk1("rst_trig_ringing", RINGING, 1);
        step(960);
        chk1("pre_reset_piezo", PIEZO, 1);
        RESET = 1;
        step(1);
        chk_out("mid_reset", 0, 0, 0);
        RESET = 0;
        step(1);
        chk_out("post_reset_retrig", 0, 1, 0);
        step(955);
        chk1("post_reset_note0_lo", PIEZO, 0);
        step(1);
        chk1("post_reset_note0_hi", PIEZO, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piezo_alarm_unit.md
Name: piezo_alarm_unit

Overview:
- Alarm tone sequencer. Sits directly downstream of the time-compare stage.
- Consumes the ALARM_DOING level and drives the PIEZO pin with a repeating 8-note square-wave melody.
- Handles stop, snooze and auto-timeout.
- Exports RINGING and SNOOZING status for the LCD controller's ring-alarm indicator.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency. Sets the note half-period table.
- NOTE_CYC, 12_500_000, clock cycles each note sounds.
- GAP_CYC, 2_500_000, silent cycles between notes.
- TIMEOUT_NOTES, 240, notes played before auto-off.
- SNOOZE_CYC, 50_000_000, silent cycles in snooze before restart.

Ports:
- CLK, input, 1, system clock. All logic on rising edge.
- RESET, input, 1, synchronous reset, active-high.
- ALARM_DOING, input, 1, alarm-match level from the time-compare stage.
- STOP, input, 1, one-cycle pulse from the key controller: silence the alarm.
- SNOOZE, input, 1, one-cycle pulse from the key controller: pause, then restart the melody.
- PIEZO, output, 1, square-wave drive to the buzzer.
- RINGING, output, 1, high in PLAY or GAP.
- SNOOZING, output, 1, high in SNOOZE_WAIT.

Behaviour:
- Reset (RESET high at a clock edge): state IDLE; PIEZO=0, RINGING=0, SNOOZING=0; all counters and note index cleared; the ALARM_DOING edge register is cleared to 0.
- Note table: HP[i] = floor(CLK_HZ / (2*F[i])).
  - F = 523, 587, 659, 698, 784, 880, 988, 1047 Hz (C5..C6).
  - Computed at elaboration; all counters 32-bit unsigned.
- Trigger: rising edge of ALARM_DOING (current 1, registered previous 0).
  - A level that stays high does not re-trigger.
  - An edge seen while not IDLE is ignored.
- IDLE:
  - PIEZO=0.
  - On trigger: next state PLAY, note index 0, played-note count 0.
  - Latency: edge sampled at cycle N, RINGING=1 from cycle N+1.
- PLAY:
  - PIEZO starts 0 on entry.
  - Tone counter counts 0..HP[idx]-1; PIEZO toggles when it wraps. First toggle is HP[idx] cycles after entry.
  - Note counter counts NOTE_CYC cycles, then goes to GAP. PIEZO is forced 0 on GAP entry and the tone counter is cleared.
- GAP:
  - PIEZO=0 for GAP_CYC cycles.
  - Then note index increments mod 8 (7 wraps to 0) and played count increments.
  - If played count == TIMEOUT_NOTES: go to IDLE (auto-off). Otherwise go to PLAY.
- SNOOZE pulse in PLAY or GAP:
  - Next state SNOOZE_WAIT; PIEZO=0; SNOOZING=1; RINGING=0.
  - Snooze counter runs SNOOZE_CYC cycles, then goes to PLAY with note index 0 and played count 0.
- SNOOZE pulse in SNOOZE_WAIT or IDLE: ignored. The snooze counter is not restarted.
- STOP pulse in PLAY, GAP or SNOOZE_WAIT:
  - Next state IDLE; PIEZO=0 on the next cycle.
  - All counters cleared.
- STOP and SNOOZE in the same cycle: STOP wins.
- STOP or SNOOZE coinciding with a note/gap/snooze expiry: STOP/SNOOZE wins over the expiry transition.
- ALARM_DOING falling while active: no effect. The melody continues until STOP, SNOOZE or timeout.
- After auto-off or STOP, re-arming requires ALARM_DOING to go low, then high again.
- RESET mid-operation: return to the reset state on the next edge, regardless of state.
- Outputs are registered; no combinational path from input to output.

Test Plan (CLK_HZ=1_000_000, NOTE_CYC=4000, GAP_CYC=1000, TIMEOUT_NOTES=16, SNOOZE_CYC=20000):
- Trigger: raise ALARM_DOING at cycle 10.
  - RINGING=1 at cycle 11.
  - PIEZO period 1912 cycles (HP[0]=956); first toggle at cycle 967.
  - PIEZO low for cycles 4011..5010.
  - Second note toggles every 851 cycles.
- Melody and timeout: hold ALARM_DOING high.
  - Half-periods follow 956, 851, 758, 716, 637, 568, 506, 477, then wrap to 956.
  - After 16 notes (80000 cycles from entry), state IDLE, RINGING=0.
  - No retrigger while ALARM_DOING stays high.
  - Drop ALARM_DOING, raise again: ringing restarts at note 0.
- Snooze: pulse SNOOZE mid-note 3.
  - Next cycle: PIEZO=0, SNOOZING=1, RINGING=0.
  - After 20000 cycles, PLAY at note 0 with played count reset.
  - A second SNOOZE pulse during the wait does not extend it.
- Stop: pulse STOP during GAP, and separately during SNOOZE_WAIT.
  - IDLE next cycle; all outputs 0.
  - STOP and SNOOZE in the same cycle: IDLE, SNOOZING stays 0.
- Reset: assert RESET for 1 cycle mid-PLAY with PIEZO=1.
  - Next edge: PIEZO=0, RINGING=0, SNOOZING=0.
  - ALARM_DOING held high through reset re-triggers after release (edge register cleared).
